// File: rtl/branch_resolver_if.sv
// Execute-stage <-> branch resolver bundle: instruction in, redirect/flush/link results out.
// master = execute stage side, slave = resolver side.
interface branch_resolver_if;
  logic        ex_valid;
  logic [5:0]  alu_code;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] npc_op1;
  logic [31:0] npc_op2;
  logic        ex_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] link_addr;
  logic        misalign_exc;

  modport master (
    output ex_valid, alu_code, pc, rs1, rs2, npc_op1, npc_op2,
    input  ex_ready, redirect_valid, redirect_pc, flush, link_addr, misalign_exc
  );

  modport slave (
    input  ex_valid, alu_code, pc, rs1, rs2, npc_op1, npc_op2,
    output ex_ready, redirect_valid, redirect_pc, flush, link_addr, misalign_exc
  );
endinterface

// File: rtl/branch_resolver.sv
// Resolves branches/jumps in execute, redirects fetch and squashes wrong-path work.
// Optional `BRANCH_STATS_EN adds br_count/taken_count statistics outputs.
`ifndef ALU_ADD
`define ALU_ADD  6'd0
`define ALU_SUB  6'd1
`define ALU_JAL  6'd16
`define ALU_JALR 6'd17
`define ALU_BEQ  6'd18
`define ALU_BNE  6'd19
`define ALU_BLT  6'd20
`define ALU_BGE  6'd21
`define ALU_BLTU 6'd22
`define ALU_BGEU 6'd23
`endif

module branch_resolver #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  branch_resolver_if.slave   br
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]        br_count,
  output logic [31:0]        taken_count
`endif
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        misalign_q, misalign_d;

  logic        accept;
  logic        is_jump;
  logic        is_ctrl;
  logic        taken;
  logic [31:0] target_sum;
  logic [31:0] target;

  always_comb begin
    is_jump = 1'b0;
    is_ctrl = 1'b1;
    taken   = 1'b0;
    case (br.alu_code)
      `ALU_JAL, `ALU_JALR: begin is_jump = 1'b1; taken = 1'b1; end
      `ALU_BEQ:  taken = (br.rs1 == br.rs2);
      `ALU_BNE:  taken = (br.rs1 != br.rs2);
      `ALU_BLT:  taken = ($signed(br.rs1) <  $signed(br.rs2));
      `ALU_BGE:  taken = ($signed(br.rs1) >= $signed(br.rs2));
      `ALU_BLTU: taken = (br.rs1 <  br.rs2);
      `ALU_BGEU: taken = (br.rs1 >= br.rs2);
      default:   is_ctrl = 1'b0;
    endcase

    target_sum = br.npc_op1 + br.npc_op2;
    target     = (br.alu_code == `ALU_JALR) ? {target_sum[31:1], 1'b0} : target_sum;

    // Anything presented while flushing is wrong-path and must leave no trace.
    accept = br.ex_valid && (state_q == IDLE);

    state_d          = state_q;
    cnt_d            = cnt_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    misalign_d       = 1'b0;
    link_addr_d      = link_addr_q;

    if (accept && is_jump) begin
      link_addr_d = br.pc + 32'd4;
    end

    if (state_q == IDLE) begin
      if (accept && taken) begin
        if (target[1]) begin
          misalign_d = 1'b1;
        end else begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          flush_d          = 1'b1;
          state_d          = FLUSH;
          cnt_d            = 3'(FLUSH_CYCLES - 1);
        end
      end
    end else begin
      // cnt_q counts remaining flush cycles after the current one.
      if (cnt_q == 3'd0) begin
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q - 3'd1;
        flush_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= 3'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      link_addr_q      <= 32'd0;
      misalign_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      link_addr_q      <= link_addr_d;
      misalign_q       <= misalign_d;
    end
  end

  assign br.ex_ready       = (state_q == IDLE);
  assign br.redirect_valid = redirect_valid_q;
  assign br.redirect_pc    = redirect_pc_q;
  assign br.flush          = flush_q;
  assign br.link_addr      = link_addr_q;
  assign br.misalign_exc   = misalign_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] taken_count_q, taken_count_d;

  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (accept && is_ctrl) begin
      br_count_d = br_count_q + 32'd1;
      if (taken) begin
        taken_count_d = taken_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q    <= 32'd0;
      taken_count_q <= 32'd0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed scenarios then random instructions
// checked against a cycle-level behavioural model.
`ifndef ALU_ADD
`define ALU_ADD  6'd0
`define ALU_SUB  6'd1
`define ALU_JAL  6'd16
`define ALU_JALR 6'd17
`define ALU_BEQ  6'd18
`define ALU_BNE  6'd19
`define ALU_BLT  6'd20
`define ALU_BGE  6'd21
`define ALU_BLTU 6'd22
`define ALU_BGEU 6'd23
`endif

module tb_branch_resolver;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolver_if bif ();
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] taken_count;
`endif

  branch_resolver #(.FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .br  (bif)
`ifdef BRANCH_STATS_EN
    ,
    .br_count    (br_count),
    .taken_count (taken_count)
`endif
  );

  typedef struct {
    bit          mis;
    logic [31:0] tgt;
    bit          jump;
    logic [31:0] link;
    logic [5:0]  op;
  } ev_t;

  ev_t         sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          busy = 0;
  logic [31:0] exp_link = 32'd0;
  logic [31:0] exp_rpc = 32'd0;
  int          exp_br = 0;
  int          exp_tk = 0;
  logic [5:0]  ops [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_taken(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      `ALU_JAL, `ALU_JALR: return 1'b1;
      `ALU_BEQ:  return a == b;
      `ALU_BNE:  return a != b;
      `ALU_BLT:  return $signed(a) <  $signed(b);
      `ALU_BGE:  return $signed(a) >= $signed(b);
      `ALU_BLTU: return a <  b;
      `ALU_BGEU: return a >= b;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic bit m_ctrl(input logic [5:0] op);
    return op inside {`ALU_JAL, `ALU_JALR, `ALU_BEQ, `ALU_BNE, `ALU_BLT,
                      `ALU_BGE, `ALU_BLTU, `ALU_BGEU};
  endfunction

  task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] n1, input logic [31:0] n2,
                       input bit valid);
    bit          acc;
    bit          tk;
    logic [31:0] tgt;
    ev_t         e;
    @(negedge clk);
    check("ex_ready", 32'(bif.ex_ready), 32'(busy == 0));
    check("flush", 32'(bif.flush), 32'(busy != 0));
    bif.ex_valid = valid;
    bif.alu_code = op;
    bif.pc       = pc;
    bif.rs1      = a;
    bif.rs2      = b;
    bif.npc_op1  = n1;
    bif.npc_op2  = n2;
    acc = valid && (busy == 0);
    tk  = m_taken(op, a, b);
    tgt = n1 + n2;
    if (op == `ALU_JALR) tgt = tgt & ~32'd1;
    if (acc && m_ctrl(op)) begin
      exp_br++;
      if (tk) exp_tk++;
    end
    if (acc && tk) begin
      e.mis  = (tgt & 32'd2) != 0;
      e.tgt  = tgt;
      e.jump = (op == `ALU_JAL) || (op == `ALU_JALR);
      e.link = pc + 32'd4;
      e.op   = op;
      sbq.push_back(e);
    end
    if (busy > 0) busy--;
    else if (acc && tk && !e.mis) busy = FC;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(`ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic check_stats();
`ifdef BRANCH_STATS_EN
    @(negedge clk);
    check("br_count", br_count, 32'(exp_br));
    check("taken_count", taken_count, 32'(exp_tk));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bif.ex_valid = 1'b0;
    #1;
    check("rst_flush", 32'(bif.flush), 32'd0);
    check("rst_ex_ready", 32'(bif.ex_ready), 32'd1);
    check("rst_redirect_valid", 32'(bif.redirect_valid), 32'd0);
    check("rst_redirect_pc", bif.redirect_pc, 32'd0);
    check("rst_link_addr", bif.link_addr, 32'd0);
    check("rst_misalign", 32'(bif.misalign_exc), 32'd0);
`ifdef BRANCH_STATS_EN
    check("rst_br_count", br_count, 32'd0);
    check("rst_taken_count", taken_count, 32'd0);
`endif
    busy = 0;
    sbq.delete();
    exp_link = 32'd0;
    exp_rpc = 32'd0;
    exp_br = 0;
    exp_tk = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the resolver reports a taken outcome.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bif.redirect_valid || bif.misalign_exc) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: redirect_valid=%0b misalign_exc=%0b pc_out=%h, none expected",
                     bif.redirect_valid, bif.misalign_exc, bif.redirect_pc);
          end else begin
            ev_t e;
            e = sbq.pop_front();
            check("event_kind", 32'({bif.redirect_valid, bif.misalign_exc}),
                  e.mis ? 32'd1 : 32'd2);
            if (!e.mis) begin
              check("redirect_pc", bif.redirect_pc, e.tgt);
              exp_rpc = e.tgt;
            end
            if (e.jump) exp_link = e.link;
            $display("[TB] op=%0d mis=%0b target=%h link=%h", e.op, e.mis, e.tgt, bif.link_addr);
          end
        end
        check("link_addr", bif.link_addr, exp_link);
        check("redirect_pc_hold", bif.redirect_pc, exp_rpc);
      end
    end
  end

  initial begin
    ops = '{`ALU_ADD, `ALU_SUB, `ALU_JAL, `ALU_JALR, `ALU_BEQ,
            `ALU_BNE, `ALU_BLT, `ALU_BGE, `ALU_BLTU, `ALU_BGEU};
    rst = 1'b1;
    bif.ex_valid = 1'b0;
    bif.alu_code = `ALU_ADD;
    bif.pc = 32'd0;
    bif.rs1 = 32'd0;
    bif.rs2 = 32'd0;
    bif.npc_op1 = 32'd0;
    bif.npc_op2 = 32'd0;
    do_reset();

    // BEQ taken, signed vs unsigned compare, JALR alignment, wrap-around.
    issue(`ALU_BEQ, 32'h100, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
    idle(3);
    issue(`ALU_BLT, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h8, 1'b1);
    idle(3);
    issue(`ALU_BLTU, 32'h304, 32'hFFFF_FFFF, 32'd1, 32'h304, 32'h8, 1'b1);
    idle(2);
    issue(`ALU_JALR, 32'h200, 32'd0, 32'd0, 32'h1001, 32'h4, 1'b1);
    idle(3);
    issue(`ALU_JALR, 32'h200, 32'd0, 32'd0, 32'h1002, 32'h0, 1'b1);
    idle(2);
    issue(`ALU_JAL, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20, 1'b1);
    idle(3);
    // Taken BNE with JALs in both flush cycles, then one in the first IDLE cycle.
    issue(`ALU_BNE, 32'h400, 32'd1, 32'd2, 32'h400, 32'h40, 1'b1);
    issue(`ALU_JAL, 32'h500, 32'd0, 32'd0, 32'h500, 32'h10, 1'b1);
    issue(`ALU_JAL, 32'h504, 32'd0, 32'd0, 32'h504, 32'h10, 1'b1);
    issue(`ALU_JAL, 32'h600, 32'd0, 32'd0, 32'h600, 32'h80, 1'b1);
    idle(3);
    check_stats();

    // Reset landing in the first flush cycle.
    issue(`ALU_BNE, 32'h700, 32'd3, 32'd4, 32'h700, 32'h100, 1'b1);
    do_reset();
    idle(4);

    // Statistics: 3 taken, 2 not-taken, 1 non-control.
    issue(`ALU_BEQ, 32'h10, 32'd7, 32'd7, 32'h10, 32'h20, 1'b1);
    idle(3);
    issue(`ALU_BNE, 32'h14, 32'd7, 32'd7, 32'h14, 32'h20, 1'b1);
    issue(`ALU_BGE, 32'h18, 32'd9, 32'd2, 32'h18, 32'h20, 1'b1);
    idle(3);
    issue(`ALU_BGEU, 32'h1C, 32'd1, 32'd2, 32'h1C, 32'h20, 1'b1);
    issue(`ALU_ADD, 32'h20, 32'd1, 32'd2, 32'h20, 32'h20, 1'b1);
    issue(`ALU_JAL, 32'h24, 32'd0, 32'd0, 32'h24, 32'h40, 1'b1);
    idle(3);
    check_stats();

    // Random instruction stream.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] n1;
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom());
      if ($urandom_range(0, 3) == 0) a = a ^ 32'h8000_0000;
      n1 = $urandom();
      issue(ops[$urandom_range(0, 9)], 32'($urandom()), a, b, n1,
            32'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0));
    end
    idle(4);
    check_stats();

    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d events still expected, required 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
